// File: rtl/crossbar_pair_sched.sv
// crossbar_pair_sched
//   Buffers PHV beats and lookup action words on two independent valid/ready
//   streams, pairs them strictly in arrival order and issues one registered
//   {phv, action} beat per cycle to the action crossbar. If a PHV has waited
//   TIMEOUT cycles at the FIFO head with no action available, it is issued
//   with an all-zero (pass-through) action and timeout_err is set. A flush
//   pulse discards all buffered beats.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   phv_in/_valid/_ready        PHV input stream
//   act_in/_valid/_ready        action word input stream (25*ACT_LEN bits)
//   xbar_phv/_act/_valid        registered pair to the crossbar (1-cycle pulse)
//   xbar_ready                  crossbar may accept a pair this cycle
//   flush                       single-cycle pulse: drop all buffered beats
//   timeout_err                 sticky: a PHV went out with a no-op action
//   pair_cnt                    pairs issued since reset (wrapping)
module crossbar_pair_sched #(
  parameter int unsigned STAGE   = 0,
  parameter int unsigned PHV_LEN = 1124,
  parameter int unsigned ACT_LEN = 25,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PHV_LEN-1:0]     phv_in,
  input  logic                   phv_in_valid,
  output logic                   phv_in_ready,
  input  logic [25*ACT_LEN-1:0]  act_in,
  input  logic                   act_in_valid,
  output logic                   act_in_ready,
  output logic [PHV_LEN-1:0]     xbar_phv,
  output logic [25*ACT_LEN-1:0]  xbar_act,
  output logic                   xbar_valid,
  input  logic                   xbar_ready,
  input  logic                   flush,
  output logic                   timeout_err,
  output logic [31:0]            pair_cnt
);

  localparam int unsigned ACT_W = 25 * ACT_LEN;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [15:0]   TO_CNT   = 16'(TIMEOUT);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       phv_wr_q, phv_wr_d, phv_rd_q, phv_rd_d;
  logic [AW-1:0]       act_wr_q, act_wr_d, act_rd_q, act_rd_d;
  logic [CW-1:0]       phv_cnt_q, phv_cnt_d, act_cnt_q, act_cnt_d;
  logic [15:0]         wait_q, wait_d;
  logic                xbar_valid_q, xbar_valid_d;
  logic [PHV_LEN-1:0]  xbar_phv_q, xbar_phv_d;
  logic [ACT_W-1:0]    xbar_act_q, xbar_act_d;
  logic                timeout_err_q, timeout_err_d;
  logic [31:0]         pair_cnt_q, pair_cnt_d;

  logic [PHV_LEN-1:0]  phv_mem [DEPTH];
  logic [ACT_W-1:0]    act_mem [DEPTH];

  logic run, phv_push, act_push, phv_ne, act_ne;
  logic issue_pair, issue_to, phv_pop, act_pop;

  // Readys are gated by rst_n so they drop immediately while in reset.
  assign phv_in_ready = rst_n && (state_q == ST_RUN) && (phv_cnt_q != FULL_CNT);
  assign act_in_ready = rst_n && (state_q == ST_RUN) && (act_cnt_q != FULL_CNT);

  always_comb begin
    state_d       = state_q;
    phv_wr_d      = phv_wr_q;
    phv_rd_d      = phv_rd_q;
    act_wr_d      = act_wr_q;
    act_rd_d      = act_rd_q;
    phv_cnt_d     = phv_cnt_q;
    act_cnt_d     = act_cnt_q;
    wait_d        = wait_q;
    xbar_valid_d  = 1'b0;
    xbar_phv_d    = xbar_phv_q;
    xbar_act_d    = xbar_act_q;
    timeout_err_d = timeout_err_q;
    pair_cnt_d    = pair_cnt_q;

    run      = (state_q == ST_RUN);
    phv_push = phv_in_valid && phv_in_ready;
    act_push = act_in_valid && act_in_ready;
    phv_ne   = (phv_cnt_q != '0);
    act_ne   = (act_cnt_q != '0);

    // Issue decisions use pre-push occupancy, so an action arriving on the
    // timeout cycle does not rescue the waiting PHV.
    issue_pair = run && !flush && xbar_ready && phv_ne && act_ne;
    issue_to   = run && !flush && xbar_ready && phv_ne && !act_ne && (wait_q == TO_CNT);
    phv_pop    = issue_pair || issue_to;
    act_pop    = issue_pair;

    if (phv_push) phv_wr_d = phv_wr_q + 1'b1;
    if (phv_pop)  phv_rd_d = phv_rd_q + 1'b1;
    if (act_push) act_wr_d = act_wr_q + 1'b1;
    if (act_pop)  act_rd_d = act_rd_q + 1'b1;

    if (phv_push && !phv_pop)      phv_cnt_d = phv_cnt_q + 1'b1;
    else if (phv_pop && !phv_push) phv_cnt_d = phv_cnt_q - 1'b1;
    if (act_push && !act_pop)      act_cnt_d = act_cnt_q + 1'b1;
    else if (act_pop && !act_push) act_cnt_d = act_cnt_q - 1'b1;

    // wait counter saturates at TIMEOUT so a stalled crossbar cannot make
    // it run past the trigger value and miss the timeout.
    if (issue_to)
      wait_d = '0;
    else if (phv_ne && !act_ne)
      wait_d = (wait_q < TO_CNT) ? wait_q + 16'd1 : wait_q;
    else
      wait_d = '0;

    if (phv_pop) begin
      xbar_valid_d = 1'b1;
      xbar_phv_d   = phv_mem[phv_rd_q];
      xbar_act_d   = issue_pair ? act_mem[act_rd_q] : '0;
      pair_cnt_d   = pair_cnt_q + 32'd1;
    end
    if (issue_to) timeout_err_d = 1'b1;

    // Flush: storage is dropped on the edge that samples the pulse; the
    // following FLUSH cycle holds everything idle and returns to RUN.
    if ((run && flush) || !run) begin
      state_d   = run ? ST_FLUSH : ST_RUN;
      phv_wr_d  = '0;
      phv_rd_d  = '0;
      act_wr_d  = '0;
      act_rd_d  = '0;
      phv_cnt_d = '0;
      act_cnt_d = '0;
      wait_d    = '0;
      if (run) timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (phv_push) phv_mem[phv_wr_q] <= phv_in;
    if (act_push) act_mem[act_wr_q] <= act_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      phv_wr_q      <= '0;
      phv_rd_q      <= '0;
      act_wr_q      <= '0;
      act_rd_q      <= '0;
      phv_cnt_q     <= '0;
      act_cnt_q     <= '0;
      wait_q        <= '0;
      xbar_valid_q  <= 1'b0;
      xbar_phv_q    <= '0;
      xbar_act_q    <= '0;
      timeout_err_q <= 1'b0;
      pair_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      phv_wr_q      <= phv_wr_d;
      phv_rd_q      <= phv_rd_d;
      act_wr_q      <= act_wr_d;
      act_rd_q      <= act_rd_d;
      phv_cnt_q     <= phv_cnt_d;
      act_cnt_q     <= act_cnt_d;
      wait_q        <= wait_d;
      xbar_valid_q  <= xbar_valid_d;
      xbar_phv_q    <= xbar_phv_d;
      xbar_act_q    <= xbar_act_d;
      timeout_err_q <= timeout_err_d;
      pair_cnt_q    <= pair_cnt_d;
    end
  end

  assign xbar_valid  = xbar_valid_q;
  assign xbar_phv    = xbar_phv_q;
  assign xbar_act    = xbar_act_q;
  assign timeout_err = timeout_err_q;
  assign pair_cnt    = pair_cnt_q;

endmodule

// File: tb/tb_crossbar_pair_sched.sv
// Directed bench for crossbar_pair_sched: small widths, TIMEOUT=12, DEPTH=8.
module tb_crossbar_pair_sched;

  localparam int unsigned PL  = 32;
  localparam int unsigned AL  = 4;
  localparam int unsigned AWD = 25 * AL;
  localparam int unsigned TO  = 12;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [PL-1:0]  phv_in;
  logic           phv_in_valid;
  logic           phv_in_ready;
  logic [AWD-1:0] act_in;
  logic           act_in_valid;
  logic           act_in_ready;
  logic [PL-1:0]  xbar_phv;
  logic [AWD-1:0] xbar_act;
  logic           xbar_valid;
  logic           xbar_ready;
  logic           flush;
  logic           timeout_err;
  logic [31:0]    pair_cnt;

  int total = 0;
  int bad   = 0;

  crossbar_pair_sched #(
    .STAGE(3), .PHV_LEN(PL), .ACT_LEN(AL), .DEPTH(8), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(phv_in_ready),
    .act_in(act_in), .act_in_valid(act_in_valid), .act_in_ready(act_in_ready),
    .xbar_phv(xbar_phv), .xbar_act(xbar_act), .xbar_valid(xbar_valid),
    .xbar_ready(xbar_ready), .flush(flush),
    .timeout_err(timeout_err), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [PL-1:0] pv(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  function automatic logic [AWD-1:0] av(input int i);
    return {4'hE, 32'hBEEF_0000 + 32'(i), 64'h1234_5678_0000_0000 + 64'(i)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pair(input string tag, input int i, input logic [AWD-1:0] a);
    chk({tag, "_valid"}, 128'(xbar_valid), 128'(1'b1));
    chk({tag, "_phv"}, 128'(xbar_phv), 128'(pv(i)));
    chk({tag, "_act"}, 128'(xbar_act), 128'(a));
  endtask

  initial begin
    rst_n = 1'b0; phv_in = '0; phv_in_valid = 1'b0; act_in = '0; act_in_valid = 1'b0;
    xbar_ready = 1'b1; flush = 1'b0;
    #2;
    chk("rst_phv_ready", 128'(phv_in_ready), 128'(1'b0));
    chk("rst_act_ready", 128'(act_in_ready), 128'(1'b0));
    chk("rst_valid", 128'(xbar_valid), 128'(1'b0));
    chk("rst_pair_cnt", 128'(pair_cnt), 128'(0));
    chk("rst_terr", 128'(timeout_err), 128'(1'b0));
    chk("rst_xphv", 128'(xbar_phv), 128'(0));
    chk("rst_xact", 128'(xbar_act), 128'(0));
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 128'({phv_in_ready, act_in_ready}), 128'(2'b11));

    // 1: PHV at edge 0, action at edge 3, pair visible after edge 4.
    phv_in = pv(0); phv_in_valid = 1'b1;
    step(); phv_in_valid = 1'b0;
    step(); step();
    chk("t1_idle", 128'(xbar_valid), 128'(1'b0));
    act_in = av(0); act_in_valid = 1'b1;
    step(); act_in_valid = 1'b0;
    chk("t1_lat", 128'(xbar_valid), 128'(1'b0));
    step();
    chk_pair("t1", 0, av(0));
    chk("t1_cnt", 128'(pair_cnt), 128'(1));
    step();
    chk("t1_pulse", 128'(xbar_valid), 128'(1'b0));

    // 2: fill PHV FIFO, then stream 8 actions.
    for (int i = 0; i < 8; i++) begin
      phv_in = pv(i); phv_in_valid = 1'b1;
      step();
      chk("t2_phv_ready", 128'(phv_in_ready), 128'(i < 7));
    end
    phv_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      act_in = av(i); act_in_valid = 1'b1;
      step();
      if (i > 0) chk_pair("t2", i - 1, av(i - 1));
    end
    act_in_valid = 1'b0;
    step();
    chk_pair("t2_last", 7, av(7));
    chk("t2_cnt", 128'(pair_cnt), 128'(9));
    chk("t2_terr", 128'(timeout_err), 128'(1'b0));
    step();
    chk("t2_end", 128'(xbar_valid), 128'(1'b0));

    // 4: crossbar stalled with three pairs buffered, then released.
    xbar_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      phv_in = pv(10 + i); phv_in_valid = 1'b1;
      act_in = av(10 + i); act_in_valid = 1'b1;
      step();
      chk("t4_stall", 128'(xbar_valid), 128'(1'b0));
    end
    phv_in_valid = 1'b0; act_in_valid = 1'b0;
    step();
    chk("t4_stall_hold", 128'(xbar_valid), 128'(1'b0));
    xbar_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_pair("t4", 10 + i, av(10 + i));
    end
    step();
    chk("t4_end", 128'(xbar_valid), 128'(1'b0));
    chk("t4_cnt", 128'(pair_cnt), 128'(12));

    // 3: timeout with no action; fires on the 13th edge after the push.
    phv_in = pv(20); phv_in_valid = 1'b1;
    step(); phv_in_valid = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("t3_before", 128'(xbar_valid), 128'(1'b0));
    step();
    chk_pair("t3", 20, '0);
    chk("t3_terr", 128'(timeout_err), 128'(1'b1));
    chk("t3_cnt", 128'(pair_cnt), 128'(13));
    step();
    chk("t3_pulse", 128'(xbar_valid), 128'(1'b0));
    chk("t3_sticky", 128'(timeout_err), 128'(1'b1));

    // Timeout coinciding with an action push: PHV still goes out with a no-op.
    phv_in = pv(21); phv_in_valid = 1'b1;
    step(); phv_in_valid = 1'b0;
    for (int i = 0; i < 12; i++) step();
    act_in = av(21); act_in_valid = 1'b1;
    step(); act_in_valid = 1'b0;
    chk_pair("t3b", 21, '0);
    chk("t3b_cnt", 128'(pair_cnt), 128'(14));

    // 5: A21 is left over; stall and add 3 PHVs, then flush.
    xbar_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      phv_in = pv(30 + i); phv_in_valid = 1'b1;
      step();
    end
    phv_in_valid = 1'b0;
    chk("t5_held", 128'(xbar_valid), 128'(1'b0));
    flush = 1'b1; xbar_ready = 1'b1;
    step(); flush = 1'b0;
    chk("t5_ready_low", 128'({phv_in_ready, act_in_ready}), 128'(2'b00));
    chk("t5_no_issue", 128'(xbar_valid), 128'(1'b0));
    chk("t5_terr_clr", 128'(timeout_err), 128'(1'b0));
    phv_in = pv(99); phv_in_valid = 1'b1;
    act_in = av(99); act_in_valid = 1'b1;
    step();
    phv_in_valid = 1'b0; act_in_valid = 1'b0;
    chk("t5_run_ready", 128'({phv_in_ready, act_in_ready}), 128'(2'b11));
    chk("t5_empty1", 128'(xbar_valid), 128'(1'b0));
    step();
    chk("t5_empty2", 128'(xbar_valid), 128'(1'b0));
    phv_in = pv(40); phv_in_valid = 1'b1;
    act_in = av(40); act_in_valid = 1'b1;
    step();
    phv_in_valid = 1'b0; act_in_valid = 1'b0;
    step();
    chk_pair("t5_new", 40, av(40));
    chk("t5_cnt", 128'(pair_cnt), 128'(15));
    chk("t5_terr", 128'(timeout_err), 128'(1'b0));

    // 6: reset in the middle of a burst.
    step();
    phv_in = pv(50); phv_in_valid = 1'b1;
    act_in = av(50); act_in_valid = 1'b1;
    step();
    phv_in = pv(51); act_in = av(51);
    step();
    chk_pair("t6_pre", 50, av(50));
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 128'(xbar_valid), 128'(1'b0));
    chk("t6_cnt", 128'(pair_cnt), 128'(0));
    chk("t6_xphv", 128'(xbar_phv), 128'(0));
    chk("t6_ready", 128'({phv_in_ready, act_in_ready}), 128'(2'b00));
    phv_in_valid = 1'b0; act_in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    chk("t6_lost", 128'(xbar_valid), 128'(1'b0));
    phv_in = pv(60); phv_in_valid = 1'b1;
    act_in = av(60); act_in_valid = 1'b1;
    step();
    phv_in_valid = 1'b0; act_in_valid = 1'b0;
    step();
    chk_pair("t6_post", 60, av(60));
    chk("t6_post_cnt", 128'(pair_cnt), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
